// File: rtl/fifo_pkg.sv
// Shared constants for the synchronous FIFO and its read-side adapters.
package fifo_pkg;

  localparam int unsigned FIFO_RD_LAT     = 1;
  localparam int unsigned OBUF_DEEP_MIN   = 2;
  localparam int unsigned DEF_DATA_W      = 32;
  localparam int unsigned DEF_OBUF_DEEP   = 3;
  localparam int unsigned DEF_OBUF_DEEP_W = 2;
  localparam int unsigned DEF_CNT_W       = 16;

endpackage

// File: rtl/fifo_rd_obuf.sv
// Small circular register buffer; the head entry is presented straight from its register.
module fifo_rd_obuf
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_OBUF_DEEP,
  parameter int unsigned PTR_W  = DEF_OBUF_DEEP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              push,
  input  logic [DATA_W-1:0] push_dat,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_dat,
  output logic [PTR_W:0]    occ
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side adapter: issues FIFO reads against buffer credit, absorbs the read latency,
// and presents the data as a valid/ready stream.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned OBUF_DEEP   = DEF_OBUF_DEEP,
  parameter int unsigned OBUF_DEEP_W = DEF_OBUF_DEEP_W,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_empty,
  output logic              fifo_rd,
  input  logic [DATA_W-1:0] fifo_rd_dat,
  input  logic              fifo_rd_dat_vld,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_dat,
  input  logic              out_rdy,
  input  logic              flush,
  output logic [CNT_W-1:0]  beat_cnt,
  output logic              err_unexp
);

  localparam int unsigned CRED_W = OBUF_DEEP_W + 2;

  if ((OBUF_DEEP < OBUF_DEEP_MIN) || (OBUF_DEEP < FIFO_RD_LAT + 1) ||
      ((2 ** OBUF_DEEP_W) < OBUF_DEEP)) begin : g_bad_cfg
    $error("fifo_rd_stream: OBUF_DEEP/OBUF_DEEP_W configuration invalid");
  end

  logic                 inflight;
  logic [OBUF_DEEP_W:0] occ;
  logic [CRED_W-1:0]    credit;
  logic                 push;
  logic                 pop;

  // Credit uses registered state only, so out_rdy never reaches fifo_rd.
  assign credit  = CRED_W'(occ) + CRED_W'(inflight);
  // Gating with rst_n keeps the strobe low during reset regardless of fifo_empty.
  assign fifo_rd = rst_n & ~fifo_empty & ~flush & (credit < CRED_W'(OBUF_DEEP));

  assign push    = fifo_rd_dat_vld & inflight & ~flush;
  assign out_vld = (occ != '0);
  assign pop     = out_vld & out_rdy & ~flush;

  fifo_rd_obuf #(
    .DATA_W (DATA_W),
    .DEPTH  (OBUF_DEEP),
    .PTR_W  (OBUF_DEEP_W)
  ) u_obuf (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (flush),
    .push     (push),
    .push_dat (fifo_rd_dat),
    .pop      (pop),
    .pop_dat  (out_dat),
    .occ      (occ)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight  <= 1'b0;
      beat_cnt  <= '0;
      err_unexp <= 1'b0;
    end else begin
      inflight <= fifo_rd;
      if (pop) beat_cnt <= beat_cnt + 1'b1;
      if (fifo_rd_dat_vld && !inflight) err_unexp <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: queue-based FIFO model, read-order scoreboard and directed scenarios.
module tb_fifo_rd_stream;

  localparam int unsigned DW   = 32;
  localparam int unsigned DEEP = 3;
  localparam int unsigned PW   = 2;
  localparam int unsigned CW   = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          fifo_rd;
  logic [DW-1:0] fifo_rd_dat;
  logic          fifo_rd_dat_vld;
  logic          out_vld;
  logic [DW-1:0] out_dat;
  logic          out_rdy = 1'b0;
  logic          flush = 1'b0;
  logic [CW-1:0] beat_cnt;
  logic          err_unexp;

  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_dat = '0;
  logic          fvld = 1'b0;
  logic [DW-1:0] fdat = '0;
  logic          stray = 1'b0;
  logic [DW-1:0] stray_dat = '0;

  always #5 clk = ~clk;

  assign fifo_rd_dat_vld = fvld | stray;
  assign fifo_rd_dat     = stray ? stray_dat : fdat;

  fifo_rd_stream #(
    .DATA_W      (DW),
    .OBUF_DEEP   (DEEP),
    .OBUF_DEEP_W (PW),
    .CNT_W       (CW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .fifo_empty      (fifo_empty),
    .fifo_rd         (fifo_rd),
    .fifo_rd_dat     (fifo_rd_dat),
    .fifo_rd_dat_vld (fifo_rd_dat_vld),
    .out_vld         (out_vld),
    .out_dat         (out_dat),
    .out_rdy         (out_rdy),
    .flush           (flush),
    .beat_cnt        (beat_cnt),
    .err_unexp       (err_unexp)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Synchronous FIFO model: one-cycle read latency, registered empty flag.
  logic [DW-1:0] fq[$];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fq.delete();
      fifo_empty <= 1'b1;
      fvld       <= 1'b0;
      fdat       <= '0;
    end else begin
      fvld <= 1'b0;
      if (fifo_rd && fq.size() > 0) begin
        fdat <= fq[0];
        fvld <= 1'b1;
        void'(fq.pop_front());
      end
      if (wr_en) fq.push_back(wr_dat);
      fifo_empty <= (fq.size() == 0);
    end
  end

  // Scoreboard: every word read from the FIFO is owed to the stream unless a flush drops it.
  typedef struct {
    logic [DW-1:0] dat;
    int            cyc;
  } ent_t;

  ent_t          exp_q[$];
  int            cyc = 0;
  int            rd_pulses = 0;
  int            delivered = 0;
  logic [DW-1:0] last_dat = '0;
  logic [CW-1:0] beat_model = '0;
  logic          err_model = 1'b0;
  logic          prev_rd = 1'b0;
  logic          exp_vld;
  ent_t          head;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      beat_model = '0;
      err_model  = 1'b0;
      prev_rd    = 1'b0;
    end else begin
      cyc++;
      chk("fifo_rd", fifo_rd, !fifo_empty && !flush && (exp_q.size() < DEEP));
      exp_vld = (exp_q.size() > 0) && (exp_q[0].cyc + 2 <= cyc);
      chk("out_vld", out_vld, exp_vld);
      chk("beat_cnt", beat_cnt, beat_model);
      chk("err_unexp", err_unexp, err_model);
      if (fifo_rd_dat_vld && !prev_rd) err_model = 1'b1;
      if (out_vld && out_rdy && !flush) begin
        chk("beat_owed", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          head = exp_q.pop_front();
          chk("out_dat", out_dat, head.dat);
        end
        delivered++;
        last_dat   = out_dat;
        beat_model = beat_model + 1'b1;
      end
      if (flush) exp_q.delete();
      if (fifo_rd) begin
        rd_pulses++;
        if (fq.size() > 0) exp_q.push_back('{fq[0], cyc});
      end
      prev_rd = fifo_rd;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input logic [DW-1:0] d);
    wr_en  = 1'b1;
    wr_dat = d;
    tick();
    wr_en  = 1'b0;
  endtask

  int r0, d0;

  initial begin
    #2;
    chk("rst_fifo_rd", fifo_rd, 0);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_out_dat", out_dat, 0);
    chk("rst_beat_cnt", beat_cnt, 0);
    chk("rst_err", err_unexp, 0);
    tick();
    rst_n = 1'b1;
    idle(2);

    // Stream of 8 words at full rate.
    out_rdy = 1'b1;
    r0 = rd_pulses;
    d0 = delivered;
    for (int i = 0; i < 8; i++) wr(DW'(32'h10 + i));
    idle(6);
    chk("stream_rd_pulses", rd_pulses - r0, 8);
    chk("stream_delivered", delivered - d0, 8);
    chk("stream_last", last_dat, 32'h17);
    chk("stream_beat_cnt", beat_cnt, 8);

    // Backpressure: only the buffer depth is read ahead.
    out_rdy = 1'b0;
    r0 = rd_pulses;
    d0 = delivered;
    for (int i = 0; i < 6; i++) wr(DW'(32'h10 + i));
    idle(6);
    chk("bp_rd_pulses", rd_pulses - r0, 3);
    chk("bp_out_vld", out_vld, 1);
    chk("bp_out_dat_hold", out_dat, 32'h10);
    out_rdy = 1'b1;
    idle(8);
    chk("bp_rd_total", rd_pulses - r0, 6);
    chk("bp_delivered", delivered - d0, 6);
    chk("bp_last", last_dat, 32'h15);

    // Empty boundary.
    r0 = rd_pulses;
    wr(32'h30);
    idle(4);
    chk("empty_one_rd", rd_pulses - r0, 1);
    wr(32'h31);
    idle(4);
    chk("empty_second_rd", rd_pulses - r0, 2);
    chk("empty_last", last_dat, 32'h31);

    // Flush while the first read is in flight.
    d0 = delivered;
    wr(32'h40);
    chk("flush_rd_issued", fifo_rd, 1);
    wr(32'h41);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_out_vld", out_vld, 0);
    idle(6);
    chk("flush_delivered", delivered - d0, 1);
    chk("flush_next_word", last_dat, 32'h41);

    // Stray valid with nothing in flight.
    out_rdy = 1'b0;
    idle(3);
    stray_dat = 32'hdead;
    stray = 1'b1;
    tick();
    stray = 1'b0;
    chk("stray_err_set", err_unexp, 1);
    chk("stray_not_captured", out_vld, 0);
    idle(5);
    chk("stray_err_sticky", err_unexp, 1);

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 1500; i++) begin
      wr_en   = ($urandom_range(1, 0) == 1);
      wr_dat  = $urandom;
      out_rdy = ($urandom_range(3, 0) != 0);
      flush   = ($urandom_range(39, 0) == 0);
      tick();
    end
    wr_en   = 1'b0;
    flush   = 1'b0;
    out_rdy = 1'b1;
    idle(200);
    chk("rand_drained_fifo", fq.size(), 0);
    chk("rand_drained_sb", exp_q.size(), 0);

    // Reset clears the sticky error; then wrap the 4-bit beat counter.
    rst_n = 1'b0;
    #1;
    chk("rst2_err", err_unexp, 0);
    chk("rst2_beat_cnt", beat_cnt, 0);
    tick();
    rst_n = 1'b1;
    d0 = delivered;
    for (int i = 0; i < 17; i++) wr(DW'(32'h100 + i));
    idle(6);
    chk("wrap_delivered", delivered - d0, 17);
    chk("wrap_beat_cnt", beat_cnt, 1);

    // Asynchronous reset mid-stream.
    wr_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_dat = DW'(32'h200 + i);
      tick();
    end
    chk("arst_pre_vld", out_vld, 1);
    chk("arst_pre_rd", fifo_rd, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_fifo_rd", fifo_rd, 0);
    chk("arst_out_vld", out_vld, 0);
    chk("arst_out_dat", out_dat, 0);
    chk("arst_beat_cnt", beat_cnt, 0);
    chk("arst_err", err_unexp, 0);
    wr_en = 1'b0;
    tick();
    rst_n = 1'b1;
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
